fifo_frame_reader: RTL and testbench
====================================

// Module: fifo_frame_reader
// PURPOSE
//  Read-side consumer of the switch's byte-wide async receive FIFO, clocked in that FIFO's read-clock domain.
//  Parses frames stored as [len_hi, len_lo, payload...] and strips the 2-byte big-endian length header.
//  Presents payload as a valid/ready byte stream with first/last markers to the forwarding logic.
//  Hides the FIFO's 1-cycle read latency behind a 2-entry skid buffer; sustains 1 byte/clk.
// PARAMETERS
//  LEN_W    12    width of frame-length counter; FIFO depth is 2^12 bytes
//  MAX_LEN  1518  largest legal payload length in bytes; larger is an error
// PORTS
//  clk              in   1      single clock; FIFO read clock
//  rst_n            in   1      asynchronous, active-low reset
//  fifo_ren         out  1      FIFO read enable
//  fifo_rdat        in   8      FIFO read data, valid 1 clk after an accepted read
//  fifo_rempty      in   1      FIFO empty flag, registered
//  m_data           out  8      payload byte
//  m_valid          out  1      m_data valid
//  m_ready          in   1      downstream accepts byte when m_valid&m_ready
//  m_first          out  1      qualifies first payload byte of a frame
//  m_last           out  1      qualifies final payload byte of a frame
//  frame_len        out  LEN_W  payload length of the most recently parsed header
//  frame_len_valid  out  1      1-clk pulse when frame_len updates
//  err_len          out  1      sticky: illegal header seen, block halted
// BEHAVIOUR
//  Clock/reset: one clock, clk; reset rst_n is asynchronous and active-low.
//  Reset values: fifo_ren=0, m_valid=0, m_first=0, m_last=0, m_data=0, frame_len=0, frame_len_valid=0, err_len=0.
//  Accepted read: rd_fire = fifo_ren & ~fifo_rempty. Data returns on fifo_rdat the next clk.
//  fifo_ren with rempty=1 is harmless and consumes nothing.
//  Issue control: fifo_ren=1 iff state!=HALT and (buffer occupancy + in-flight payload reads) < 2.
//  Header reads bypass the occupancy test.
//  Issue-side FSM advances on rd_fire and tags each in-flight read HDR_HI, HDR_LO or PAY:
//   HDR_HI -> HDR_LO -> PAY (stays until remaining count reaches 0) -> HDR_HI.
//   Payload reads may continue into the next header without a gap.
//  Return side, HDR_HI: latches the high byte.
//  Return side, HDR_LO: len = {hi,lo}.
//   If len==0, len>MAX_LEN, or hi bits above LEN_W are set: err_len<=1 and state=HALT.
//   Otherwise: frame_len<=len, frame_len_valid pulses one clk, remaining counter loads len.
//  HALT: fifo_ren=0 forever; stream stalls after draining bytes already buffered; exit only via rst_n.
//   In-flight header-tagged reads are dropped.
//  Header bytes never enter the skid buffer and never appear on m_data.
//  Skid buffer: 2-entry FIFO of {data, first, last}; m_* driven from the head entry (registered output).
//   Push on PAY return; pop on m_valid&m_ready.
//   Push and pop in the same clk with occupancy 2 is legal; buffer never overflows by construction.
//  m_first on the first PAY byte after a header; m_last on the byte where the remaining count reaches 0.
//   Both set on the same byte when len==1.
//  m_data/m_first/m_last are held stable while m_valid&~m_ready.
//  Latency: header-hi read accepted at clk N with FIFO non-empty and m_ready=1 -> first payload m_valid at N+4.
//  FIFO empty mid-frame: reads stall and m_valid drops when the buffer drains; order is preserved and nothing duplicates.
//  Remaining counter is LEN_W bits with no wrap; it is only decremented while nonzero.
//  Reset mid-frame: all state clears and in-flight reads are discarded; the FIFO is reset by the same reset tree.
//   The next byte read is treated as HDR_HI.
// STRUCTURE
//  Shared package switch_pkg holds:
//   HDR_BYTES=2, MAX_FRAME_LEN=1518, FIFO_AW=12;
//   rd_tag_t enum {TAG_HDR_HI, TAG_HDR_LO, TAG_PAY};
//   state_t enum {S_HDR_HI, S_HDR_LO, S_PAY, S_HALT}.
//  One sub-module: byte_skid_buf (2-entry {data,first,last} buffer, valid/ready out, occupancy out).
//  Top level holds the issue FSM, tag pipeline register, length check and remaining counter.
// TESTING
//  T1 len=3, payload AA BB CC, m_ready=1:
//     frame_len_valid pulses once with frame_len=3;
//     m_data AA,BB,CC with m_first on AA and m_last on CC;
//     exactly 5 rd_fire.
//  T2 len=6 with m_ready pattern 1,0,1,0...:
//     all 6 bytes delivered in order, no loss or duplication;
//     occupancy+in-flight never exceeds 2.
//  T3 back-to-back len=1 (11) then len=2 (22 33), m_ready=1:
//     11 carries m_first=m_last=1; 33 carries m_last;
//     second frame_len_valid pulse with frame_len=2.
//  T4 fifo_rempty forced high 5 clks mid-payload:
//     m_valid drops after the buffer drains, then resumes with the next byte in order.
//  T5 header 0x0000, and separately 0x0700 (1792>MAX_LEN):
//     err_len=1, frame_len_valid never pulses, fifo_ren stays 0 until rst_n.
//  T6 rst_n low for 1 clk mid-payload of a len=10 frame:
//     all outputs return to reset values;
//     after refilling the FIFO, the next header parses correctly and delivers its payload.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch receive path.
// Read tags follow each FIFO read through its 1-cycle latency.
package switch_pkg;

    localparam int HDR_BYTES     = 2;
    localparam int MAX_FRAME_LEN = 1518;
    localparam int FIFO_AW       = 12;

    typedef enum logic [1:0] {
        TAG_HDR_HI,
        TAG_HDR_LO,
        TAG_PAY
    } rd_tag_t;

    typedef enum logic [1:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_PAY,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } skid_ent_t;

    function automatic rd_tag_t tag_of(input state_t s);
        case (s)
            S_HDR_HI: tag_of = TAG_HDR_HI;
            S_HDR_LO: tag_of = TAG_HDR_LO;
            default:  tag_of = TAG_PAY;
        endcase
    endfunction

endpackage

// File: rtl/byte_skid_buf.sv
// Two-entry {data,first,last} buffer; the head entry drives the outputs
// directly from flops so m_* stay stable while stalled.
module byte_skid_buf
    import switch_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_first,
    input  logic       i_last,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_first,
    output logic       o_last,
    output logic [1:0] o_occ
);

    skid_ent_t  r_head;
    skid_ent_t  r_tail;
    logic [1:0] r_occ;
    skid_ent_t  w_in;
    logic       w_pop;

    assign w_in  = {i_data, i_first, i_last};
    assign w_pop = i_ready && (r_occ != 2'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= w_in;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && w_pop) begin
                        r_head <= w_in;
                    end else if (i_push) begin
                        r_tail <= w_in;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    // Full: the issue side never pushes here without a pop.
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail <= w_in;
                        else        r_occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_head.data;
    assign o_first = r_head.first & o_valid;
    assign o_last  = r_head.last & o_valid;
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side frame parser for the byte-wide receive FIFO: strips the 2-byte
// big-endian length header and streams the payload with first/last markers.
module fifo_frame_reader
    import switch_pkg::*;
#(
    parameter int LEN_W   = FIFO_AW,
    parameter int MAX_LEN = MAX_FRAME_LEN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_fifo_ren,
    input  logic [7:0]       i_fifo_rdat,
    input  logic             i_fifo_rempty,
    output logic [7:0]       o_m_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic             o_m_first,
    output logic             o_m_last,
    output logic [LEN_W-1:0] o_frame_len,
    output logic             o_frame_len_valid,
    output logic             o_err_len
);

    state_t                  r_state;
    rd_tag_t                 r_tag;
    logic                    r_tag_vld;
    logic                    r_live;
    logic [7:0]              r_hi;
    logic [LEN_W-1:0]        r_iss_rem;
    logic [LEN_W-1:0]        r_rem;
    logic                    r_first_pend;

    logic [8*HDR_BYTES-1:0]  w_len;
    logic                    w_len_ok;
    logic                    w_hi_ret;
    logic                    w_lo_ret;
    logic                    w_pay_ret;
    logic [LEN_W-1:0]        w_iss_rem;
    logic [1:0]              w_occ;
    logic                    w_pop;
    logic [2:0]              w_eff;
    logic                    w_room;
    logic                    w_ren;
    logic                    w_fire;

    assign w_hi_ret  = r_tag_vld && (r_tag == TAG_HDR_HI) && (r_state != S_HALT);
    assign w_lo_ret  = r_tag_vld && (r_tag == TAG_HDR_LO) && (r_state != S_HALT);
    assign w_pay_ret = r_tag_vld && (r_tag == TAG_PAY);

    assign w_len    = {r_hi, i_fifo_rdat};
    assign w_len_ok = (w_len != '0) && (w_len <= 16'(MAX_LEN)) && ((w_len >> LEN_W) == '0);

    // The low header byte returns on the first S_PAY cycle, so its length
    // seeds the issue count in that same cycle and payload reads start at once.
    assign w_iss_rem = w_lo_ret ? w_len[LEN_W-1:0] : r_iss_rem;

    // Occupancy is judged after this cycle's pop so a full-rate stream
    // never leaves a bubble; occupancy+in-flight still never exceeds 2.
    assign w_pop  = o_m_valid && i_m_ready;
    assign w_eff  = {1'b0, w_occ} + {2'b0, w_pay_ret} - {2'b0, w_pop};
    assign w_room = (w_eff < 3'd2);

    always_comb begin
        w_ren = 1'b0;
        if (r_live) begin
            case (r_state)
                S_HDR_HI, S_HDR_LO: w_ren = 1'b1;
                S_PAY:   w_ren = w_room && (w_iss_rem != '0) && !(w_lo_ret && !w_len_ok);
                default: w_ren = 1'b0;
            endcase
        end
    end

    assign w_fire     = w_ren && !i_fifo_rempty;
    assign o_fifo_ren = w_ren;

    // Issue side: state advances on accepted reads, each read is tagged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_HDR_HI;
            r_live    <= 1'b0;
            r_tag_vld <= 1'b0;
            r_tag     <= TAG_HDR_HI;
            r_iss_rem <= '0;
        end else begin
            r_live    <= 1'b1;
            r_tag_vld <= w_fire;
            if (w_fire) r_tag <= tag_of(r_state);
            if (w_lo_ret && !w_len_ok) begin
                r_state <= S_HALT;
            end else begin
                case (r_state)
                    S_HDR_HI: if (w_fire) r_state <= S_HDR_LO;
                    S_HDR_LO: if (w_fire) r_state <= S_PAY;
                    S_PAY: begin
                        if (w_fire) begin
                            r_iss_rem <= w_iss_rem - LEN_W'(1);
                            if (w_iss_rem == LEN_W'(1)) r_state <= S_HDR_HI;
                        end else begin
                            r_iss_rem <= w_iss_rem;
                        end
                    end
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    // Return side: header parse, length check and first/last marking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi              <= 8'd0;
            r_rem             <= '0;
            r_first_pend      <= 1'b0;
            o_frame_len       <= '0;
            o_frame_len_valid <= 1'b0;
            o_err_len         <= 1'b0;
        end else begin
            o_frame_len_valid <= 1'b0;
            if (w_hi_ret) r_hi <= i_fifo_rdat;
            if (w_lo_ret) begin
                if (!w_len_ok) begin
                    o_err_len <= 1'b1;
                end else begin
                    o_frame_len       <= w_len[LEN_W-1:0];
                    o_frame_len_valid <= 1'b1;
                    r_rem             <= w_len[LEN_W-1:0];
                    r_first_pend      <= 1'b1;
                end
            end
            if (w_pay_ret) begin
                r_first_pend <= 1'b0;
                if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

    byte_skid_buf u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_pay_ret),
        .i_data  (i_fifo_rdat),
        .i_first (r_first_pend),
        .i_last  (r_rem == LEN_W'(1)),
        .o_valid (o_m_valid),
        .i_ready (i_m_ready),
        .o_data  (o_m_data),
        .o_first (o_m_first),
        .o_last  (o_m_last),
        .o_occ   (w_occ)
    );

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized scoreboard bench for fifo_frame_reader with a behavioural
// receive-FIFO model and a frame-level expected-byte queue.
module tb_fifo_frame_reader;

    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ren;
    logic [7:0]       rdat = 8'd0;
    logic             rempty = 1'b1;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_first;
    logic             m_last;
    logic [LEN_W-1:0] frame_len;
    logic             flv;
    logic             err;

    always #5 clk = ~clk;

    fifo_frame_reader #(.LEN_W(LEN_W), .MAX_LEN(1518)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .o_fifo_ren        (ren),
        .i_fifo_rdat       (rdat),
        .i_fifo_rempty     (rempty),
        .o_m_data          (m_data),
        .o_m_valid         (m_valid),
        .i_m_ready         (m_ready),
        .o_m_first         (m_first),
        .o_m_last          (m_last),
        .o_frame_len       (frame_len),
        .o_frame_len_valid (flv),
        .o_err_len         (err)
    );

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
    } exp_t;

    exp_t       expq[$];
    int         lenq[$];
    logic [7:0] fq[$];
    bit         hq[$];
    exp_t       mon_e;

    int n_vec = 0, n_err = 0, cyc = 0;
    int fire_cnt = 0, pay_rd = 0, acc_cnt = 0, flv_cnt = 0;
    int first_fire_cyc = -1, first_valid_cyc = -1;
    int rdy_mode = 0;
    bit rdy_tog = 1'b1, force_empty = 1'b0, rnd_empty = 1'b0;
    bit hflag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Receive FIFO: registered empty flag, data one clock after an accepted read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            hq.delete();
            rempty <= 1'b1;
            rdat   <= 8'd0;
        end else begin
            if (ren && !rempty) begin
                rdat <= fq.pop_front();
                hflag = hq.pop_front();
                if (!hflag) pay_rd++;
                fire_cnt++;
            end
            rempty <= (fq.size() == 0) || force_empty;
        end
    end

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin m_ready = rdy_tog; rdy_tog = ~rdy_tog; end
            default: m_ready = ($urandom % 3) != 0;
        endcase
        if (rnd_empty) force_empty = ($urandom % 6) == 0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("occ_plus_inflight_le2", 32'(pay_rd - acc_cnt <= 2), 1);
            if (ren && !rempty && first_fire_cyc < 0) first_fire_cyc = cyc;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                acc_cnt++;
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got 0x%0h expected no byte", m_data);
                end else begin
                    mon_e = expq.pop_front();
                    chk("m_data", m_data, mon_e.d);
                    chk("m_first", m_first, mon_e.f);
                    chk("m_last", m_last, mon_e.l);
                end
            end
            if (flv) begin
                flv_cnt++;
                if (lenq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame_len_valid: got pulse len=%0d expected none", frame_len);
                end else begin
                    chk("frame_len", frame_len, lenq.pop_front());
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit h);
        fq.push_back(b);
        hq.push_back(h);
    endtask

    task automatic push_frame(input int len, input bit rnd, input logic [7:0] base);
        logic [15:0] l16;
        logic [7:0]  b;
        l16 = 16'(len);
        push_byte(l16[15:8], 1'b1);
        push_byte(l16[7:0], 1'b1);
        lenq.push_back(len);
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(base + 8'(8'h11 * i));
            push_byte(b, 1'b0);
            expq.push_back('{b, (i == 0), (i == len - 1)});
        end
    endtask

    task automatic push_bad(input logic [15:0] h);
        push_byte(h[15:8], 1'b1);
        push_byte(h[7:0], 1'b1);
        for (int i = 0; i < 3; i++) push_byte(8'(8'h5A + i), 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++) @(negedge clk);
        chk(name, expq.size(), 0);
        step(4);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_fifo_ren", ren, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_first", m_first, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_frame_len_valid", flv, 0);
        chk("rst_err_len", err, 0);
        expq.delete();
        lenq.delete();
        pay_rd  = 0;
        acc_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
    endtask

    logic [15:0] bad_hdr[4] = '{16'h0000, 16'h0700, 16'h05EF, 16'h1001};

    initial begin
        int a0, bad_ren;
        do_reset();

        // T1: len=3, AA BB CC, full-rate sink, latency and read count
        rdy_mode = 0;
        fire_cnt = 0; flv_cnt = 0; first_fire_cyc = -1; first_valid_cyc = -1;
        push_frame(3, 1'b0, 8'hAA);
        wait_drain("t1_drain", 100);
        chk("t1_rd_fires", fire_cnt, 5);
        chk("t1_flv_pulses", flv_cnt, 1);
        chk("t1_latency", 32'(first_valid_cyc - first_fire_cyc), 4);

        // T2: len=6 with alternating ready
        rdy_mode = 1;
        push_frame(6, 1'b0, 8'h31);
        wait_drain("t2_drain", 200);

        // T3: back-to-back len=1 then len=2
        rdy_mode = 0; flv_cnt = 0;
        push_frame(1, 1'b0, 8'h11);
        push_frame(2, 1'b0, 8'h22);
        wait_drain("t3_drain", 100);
        chk("t3_flv_pulses", flv_cnt, 2);

        // T4: FIFO looks empty for 5 clocks mid-payload
        a0 = acc_cnt;
        push_frame(20, 1'b1, 8'h00);
        for (int i = 0; i < 200 && acc_cnt < a0 + 5; i++) @(negedge clk);
        chk("t4_reached_mid", 32'(acc_cnt >= a0 + 5), 1);
        force_empty = 1'b1;
        bad_ren = 0;
        repeat (5) begin
            @(negedge clk);
            if (!m_valid) bad_ren = 1;
        end
        force_empty = 1'b0;
        chk("t4_valid_dropped", bad_ren, 1);
        wait_drain("t4_drain", 200);

        // Largest legal frame
        push_frame(1518, 1'b1, 8'h00);
        wait_drain("max_len_drain", 4000);

        // T5: illegal headers halt the reader until reset
        foreach (bad_hdr[k]) begin
            flv_cnt = 0;
            push_bad(bad_hdr[k]);
            for (int i = 0; i < 50 && !err; i++) @(negedge clk);
            chk("t5_err_len", err, 1);
            bad_ren = 0;
            repeat (20) begin
                @(negedge clk);
                if (ren) bad_ren++;
            end
            chk("t5_ren_low", bad_ren, 0);
            chk("t5_no_flv", flv_cnt, 0);
            do_reset();
        end

        // T6: reset mid-payload, then a fresh frame parses cleanly
        push_frame(10, 1'b1, 8'h00);
        for (int i = 0; i < 100 && acc_cnt < 3; i++) @(negedge clk);
        chk("t6_reached_mid", 32'(acc_cnt >= 3), 1);
        do_reset();
        flv_cnt = 0;
        push_frame(4, 1'b1, 8'h00);
        wait_drain("t6_drain", 100);
        chk("t6_flv_pulses", flv_cnt, 1);

        // Random frames, random backpressure and empty gaps
        rdy_mode = 2; rnd_empty = 1'b1;
        for (int f = 0; f < 25; f++) push_frame($urandom_range(1, 48), 1'b1, 8'h00);
        wait_drain("rand_drain", 20000);
        rnd_empty = 1'b0; force_empty = 1'b0; rdy_mode = 0;
        chk("rand_len_queue_empty", lenq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
